// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
package reg_file_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Register file bus: issue/writeback side is master, the register file is slave.
// Strobes (wr_en, sb_set_en, sb_flush) act on the rising clock edge; reads are combinational.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 2,
    parameter int NWR  = 1
) ();
    localparam int AW = addr_w(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;
    logic                sb_flush;
    logic [AW:0]         sb_busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_clr, sb_set_en, sb_set_addr, sb_flush,
        input  rd_data, rd_busy, sb_busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, sb_set_en, sb_set_addr, sb_flush,
        output rd_data, rd_busy, sb_busy_cnt
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: busy bits, set/clear/flush priority, incremental busy count.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREG     = NREG_DEFAULT,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_w(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_sb_set_en,
    input  logic [AW-1:0]     i_sb_set_addr,
    input  logic              i_sb_flush,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR-1:0]    i_wr_clr,
    input  logic [NWR*AW-1:0] i_wr_addr,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy,
    output logic [AW:0]       o_busy_cnt
);
    localparam int CW = AW + 1;

    logic [NREG-1:0] r_busy;
    logic [CW-1:0]   r_cnt;
    logic [NREG-1:0] w_busy_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_dec;
    logic            w_inc;
    logic            w_set_ok;
    logic            w_dup;
    logic [AW-1:0]   w_ca;
    logic [AW-1:0]   w_ra;
    logic            w_rb;

    // A clear counts once per distinct busy address, and not when a same-cycle set re-arms it.
    always_comb begin
        w_busy_nxt = r_busy;
        w_dec      = '0;
        w_dup      = 1'b0;
        w_ca       = '0;
        w_set_ok   = i_sb_set_en && !(ZERO_REG != 0 && i_sb_set_addr == '0);
        for (int w = 0; w < NWR; w++) begin
            if (i_wr_en[w] && i_wr_clr[w]) begin
                w_ca             = i_wr_addr[w*AW +: AW];
                w_busy_nxt[w_ca] = 1'b0;
                w_dup            = 1'b0;
                for (int v = w + 1; v < NWR; v++) begin
                    if (i_wr_en[v] && i_wr_clr[v] && i_wr_addr[v*AW +: AW] == w_ca)
                        w_dup = 1'b1;
                end
                if (r_busy[w_ca] && !w_dup && !(w_set_ok && i_sb_set_addr == w_ca))
                    w_dec = w_dec + CW'(1);
            end
        end
        w_inc = w_set_ok && !r_busy[i_sb_set_addr];
        if (w_set_ok)
            w_busy_nxt[i_sb_set_addr] = 1'b1;
        if (ZERO_REG != 0)
            w_busy_nxt[0] = 1'b0;
        if (i_sb_flush)
            w_busy_nxt = '0;
        w_cnt_nxt = i_sb_flush ? '0 : r_cnt + CW'(w_inc) - w_dec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        o_rd_busy = '0;
        w_ra      = '0;
        w_rb      = 1'b0;
        for (int r = 0; r < NRD; r++) begin
            w_ra = i_rd_addr[r*AW +: AW];
            w_rb = r_busy[w_ra];
            for (int w = 0; w < NWR; w++) begin
                if (BYPASS != 0 && i_wr_en[w] && i_wr_clr[w] && i_wr_addr[w*AW +: AW] == w_ra)
                    w_rb = 1'b0;
            end
            if (ZERO_REG != 0 && w_ra == '0)
                w_rb = 1'b0;
            o_rd_busy[r] = w_rb;
        end
    end

    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with hardwired x0, write-to-read bypass and busy scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREG     = NREG_DEFAULT,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    reg_file_mp_if.slave  bus
);
    localparam int AW = addr_w(NREG);

    logic [XLEN-1:0] r_regs [NREG];
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rv;
    logic [AW-1:0]   w_wa;

    // Ascending port order lets the highest-indexed writer win on an address collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && !(ZERO_REG != 0 && bus.wr_addr[w*AW +: AW] == '0))
                    r_regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
            end
        end
    end

    // Forwarding is gated by reset so reads stay zero while reset is held.
    always_comb begin
        bus.rd_data = '0;
        w_ra        = '0;
        w_rv        = '0;
        w_wa        = '0;
        for (int r = 0; r < NRD; r++) begin
            w_ra = bus.rd_addr[r*AW +: AW];
            w_rv = r_regs[w_ra];
            for (int w = 0; w < NWR; w++) begin
                w_wa = bus.wr_addr[w*AW +: AW];
                if (BYPASS != 0 && reset_n && bus.wr_en[w] && w_wa == w_ra)
                    w_rv = bus.wr_data[w*XLEN +: XLEN];
            end
            if (ZERO_REG != 0 && w_ra == '0)
                w_rv = '0;
            bus.rd_data[r*XLEN +: XLEN] = w_rv;
        end
    end

    reg_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .NWR      (NWR),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_sb_set_en   (bus.sb_set_en),
        .i_sb_set_addr (bus.sb_set_addr),
        .i_sb_flush    (bus.sb_flush),
        .i_wr_en       (bus.wr_en),
        .i_wr_clr      (bus.wr_clr),
        .i_wr_addr     (bus.wr_addr),
        .i_rd_addr     (bus.rd_addr),
        .o_rd_busy     (bus.rd_busy),
        .o_busy_cnt    (bus.sb_busy_cnt)
    );

endmodule
